// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes and FSM states.
// Ports: none (package only).
package alu_pkg;

   typedef enum logic [1:0] {
      FUNC_ADD = 2'b00,
      FUNC_SUB = 2'b01,
      FUNC_MUL = 2'b10,
      FUNC_DIV = 2'b11
   } func_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Start/done request bus between the controller (master) and the ALU (slave).
// Signals: start, a, b, func (request); busy, done, out, ovf, dz (response).
interface alu_seq_if
   import alu_pkg::*;
#(
   parameter int width = 6
);

   logic               start;
   logic [width-1:0]   a;
   logic [width-1:0]   b;
   func_e              func;
   logic               busy;
   logic               done;
   logic [2*width-1:0] out;
   logic               ovf;
   logic               dz;

   modport master (
      output start, a, b, func,
      input  busy, done, out, ovf, dz
   );

   modport slave (
      input  start, a, b, func,
      output busy, done, out, ovf, dz
   );

endinterface

// File: rtl/muldiv_seq.sv
// Shared iterative datapath: shift-add multiply / restoring divide, 1 bit per cycle.
// Ports: clk, rst_n, init/mode/a/b (load), en (iterate), last, res (next result).
module muldiv_seq #(
   parameter int width = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               init,
   input  logic               en,
   input  logic               mode,
   input  logic [width-1:0]   a,
   input  logic [width-1:0]   b,
   output logic               last,
   output logic [2*width-1:0] res
);

   localparam int CW = $clog2(width + 1);

   // hi: upper product half / partial remainder
   // lo: multiplier (shifts out) / dividend->quotient
   logic [width-1:0] hi;
   logic [width-1:0] hi_n;
   logic [width-1:0] lo;
   logic [width-1:0] lo_n;
   logic [width-1:0] opnd;
   logic             md;
   logic [CW-1:0]    cnt;
   logic [width:0]   shl;
   logic [width:0]   sum;
   logic [width+1:0] x;
   logic [width+1:0] s;
   logic             qb;

   always_comb begin
      shl  = {hi, lo[width-1]};
      x    = md ? {1'b0, shl} : {2'b0, hi};
      s    = md ? x - {2'b0, opnd} : x + {2'b0, opnd};
      qb   = ~s[width+1];
      sum  = '0;
      hi_n = hi;
      lo_n = lo;
      res  = '0;
      if (md) begin
         // restore by keeping the shifted value when the trial goes negative;
         // a restored remainder is always below the divisor, so it fits width bits
         hi_n = qb ? s[width-1:0] : shl[width-1:0];
         lo_n = {lo[width-2:0], qb};
         res  = {lo_n, hi_n};
      end else begin
         sum  = lo[0] ? s[width:0] : {1'b0, hi};
         hi_n = sum[width:1];
         lo_n = {sum[0], lo[width-1:1]};
         res  = {hi_n, lo_n};
      end
   end

   assign last = en && (cnt == CW'(width - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi   <= '0;
         lo   <= '0;
         opnd <= '0;
         md   <= 1'b0;
         cnt  <= '0;
      end else if (init) begin
         hi   <= '0;
         lo   <= mode ? a : b;
         opnd <= mode ? b : a;
         md   <= mode;
         cnt  <= '0;
      end else if (en) begin
         hi   <= hi_n;
         lo   <= lo_n;
         cnt  <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: 1-cycle ADD/SUB, width-cycle MUL/DIV on a shared datapath.
// Ports: clk, rst_n, bus (alu_seq_if.slave: start/a/b/func -> busy/done/out/ovf/dz).
module alu_seq
   import alu_pkg::*;
#(
   parameter int width = 6
) (
   input logic       clk,
   input logic       rst_n,
   alu_seq_if.slave  bus
);

   state_e             state;
   state_e             state_n;
   logic               init;
   logic               en;
   logic               ld;
   logic               last;
   logic [2*width-1:0] md_res;
   logic [2*width-1:0] out_n;
   logic               ovf_n;
   logic               dz_n;
   logic [width:0]     add_r;
   logic [width:0]     sub_r;
   logic               busy_q;
   logic               done_q;
   logic [2*width-1:0] out_q;
   logic               ovf_q;
   logic               dz_q;

   muldiv_seq #(.width(width)) u_md (
      .clk   (clk),
      .rst_n (rst_n),
      .init  (init),
      .en    (en),
      .mode  (bus.func == FUNC_DIV),
      .a     (bus.a),
      .b     (bus.b),
      .last  (last),
      .res   (md_res)
   );

   // top bit is carry for ADD, borrow for SUB
   assign add_r = {1'b0, bus.a} + {1'b0, bus.b};
   assign sub_r = {1'b0, bus.a} - {1'b0, bus.b};

   always_comb begin
      state_n = state;
      init    = 1'b0;
      en      = 1'b0;
      ld      = 1'b0;
      out_n   = '0;
      ovf_n   = 1'b0;
      dz_n    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               unique case (1'b1)
                  bus.func == FUNC_ADD: begin
                     ld      = 1'b1;
                     out_n   = {{width{1'b0}}, add_r[width-1:0]};
                     ovf_n   = add_r[width];
                     state_n = DONE;
                  end
                  bus.func == FUNC_SUB: begin
                     ld      = 1'b1;
                     out_n   = {{width{1'b0}}, sub_r[width-1:0]};
                     ovf_n   = sub_r[width];
                     state_n = DONE;
                  end
                  bus.func == FUNC_DIV && bus.b == '0: begin
                     ld      = 1'b1;
                     out_n   = {{width{1'b1}}, bus.a};
                     dz_n    = 1'b1;
                     state_n = DONE;
                  end
                  default: begin
                     init    = 1'b1;
                     state_n = CALC;
                  end
               endcase
            end
         end
         CALC: begin
            en = 1'b1;
            if (last) begin
               ld      = 1'b1;
               out_n   = md_res;
               state_n = DONE;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         out_q  <= '0;
         ovf_q  <= 1'b0;
         dz_q   <= 1'b0;
      end else begin
         state  <= state_n;
         busy_q <= (state_n != IDLE);
         done_q <= (state_n == DONE);
         if (ld) begin
            out_q <= out_n;
            ovf_q <= ovf_n;
            dz_q  <= dz_n;
         end
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.out  = out_q;
   assign bus.ovf  = ovf_q;
   assign bus.dz   = dz_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle, parametrised successor to the single-cycle combinational ALU. It accepts one operation per start/done handshake and computes add and subtract in one cycle. Multiply (shift-add) and divide (restoring) run iteratively over `width` cycles on a shared datapath, so no full-array multiplier or divider is built. Results, overflow and divide-by-zero flags are registered and held until the next operation completes. The block sits where the combinational ALU sat, behind a controller that issues `start` and waits for `done`.

## Interface
- `width`, 6: operand width in bits. Minimum 2. Results are `2*width` bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request. Sampled only while `busy`=0.
- `a`  in  `width`  operand A, unsigned. Sampled with `start`.
- `b`  in  `width`  operand B, unsigned. Sampled with `start`.
- `func`  in  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 DIV. Sampled with `start`.
- `busy`  out  1  high from the cycle after acceptance through the `done` cycle.
- `done`  out  1  one-cycle pulse. `out`/`ovf`/`dz` are valid from this cycle on.
- `out`  out  `2*width`  result. ADD/SUB are zero-extended, MUL is the full product, DIV is {quotient, remainder}.
- `ovf`  out  1  ADD carry-out, or SUB borrow (a<b). 0 for MUL/DIV.
- `dz`  out  1  DIV with b==0. 0 for all other operations.

## Operation
- States: IDLE, CALC, DONE. `busy` = (state != IDLE).
- IDLE with `start`=1 at a clock edge:
  - Latch `a`, `b`, `func`.
  - ADD/SUB: compute the result at that edge, load the registers, go to DONE.
  - DIV with b==0: load `out`={all ones, a}, `dz`=1, `ovf`=0, go to DONE.
  - MUL/DIV otherwise: clear the iteration counter, go to CALC.
- CALC runs exactly `width` iterations, one per cycle. The counter is `$clog2(width+1)` bits.
  - MUL: unsigned shift-add, LSB-first over B. 2*width accumulator. Cannot overflow.
  - DIV: restoring, MSB-first. `width+1` bit partial remainder. Quotient bit = 1 when the trial subtract is non-negative.
  - After the last iteration, load `out` and flags, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `out`, `ovf` and `dz` hold their value until the next DONE load. A new operation's load overwrites all three.
- `start` while `busy`=1 is ignored. There is no queueing. `start` in the DONE cycle is also ignored.
- Operand changes after acceptance have no effect.
- Reset, asynchronous and at any point including mid-CALC: state goes to IDLE and every output goes to 0 (`busy`, `done`, `out`, `ovf`, `dz`). The in-flight operation is discarded and no `done` is produced for it.

## Timing
- Cycle 0 is the edge where `start` is accepted.
- ADD/SUB/DIV-by-zero: `busy` and `done` are high in cycle 1. Latency 1. Throughput 1 per 2 cycles.
- MUL/DIV: `busy` is high for cycles 1..`width`+1, and `done` is high in cycle `width`+1. Throughput 1 per `width`+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `alu_pkg`:
  - `func` encodings FUNC_ADD/SUB/MUL/DIV.
  - State enum (IDLE/CALC/DONE).
- Sub-module `muldiv_seq`: the shared iterative datapath.
  - Contains the accumulator/remainder register, shifter, adder-subtractor and counter.
  - Signals: `init`, `mode`, and `last`, which it asserts on the final iteration.
- The FSM, ADD/SUB logic and output registers stay in `alu_seq`.

## Test plan
All scenarios use `width`=6.
- ADD a=45, b=30: `out`=12'd11, `ovf`=1, `done` in cycle 1. Repeat with a=20, b=30: `out`=50, `ovf`=0.
- SUB a=10, b=20: `out`=12'd54, `ovf`=1. SUB a=20, b=10: `out`=10, `ovf`=0.
- MUL a=63, b=63: `out`=12'd3969, `busy` high in cycles 1..7, `done` in cycle 7. MUL a=0, b=37: `out`=0.
- DIV a=50, b=7: `out`={6'd7, 6'd1}=12'd449, `dz`=0, `done` in cycle 7. DIV a=13, b=0: `out`={6'h3F, 6'd13}, `dz`=1, `done` in cycle 1.
- MUL 5×9 accepted, then `start` pulsed with ADD in cycles 3 and 7: it is ignored, and `out`=45 in cycle 7.
- Reset asserted in cycle 3 of a DIV: all outputs go to 0 immediately and no `done` follows. The next ADD 1+1 gives `out`=2.
